count_cmd_sequencer: RTL

- Upstream command stage for the 4-bit up/down counter.
- Buffers step commands from a producer in a small FIFO, then expands each command into per-cycle up_down / down_up strobes that drive the counter directly.
- Also drives the counter's 4-bit data input with the active command's length field, for the counter's later load feature.
- Producer side uses a valid/ready handshake; counter side is strobe-only, with no back-pressure.

---
 rtl/count_cmd_sequencer_pkg.sv | 30 +++
 rtl/seq_cmd_fifo.sv | 65 ++++++
 rtl/seq_strobe_chk.sv | 11 +
 rtl/count_cmd_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/count_cmd_sequencer_pkg.sv
// Shared types and defaults for the counter command sequencer.
package count_seq_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_LEN_W = 4;

  typedef enum logic [1:0] {
    OP_UP      = 2'b00,
    OP_DOWN    = 2'b01,
    OP_WAIT    = 2'b10,
    OP_ILLEGAL = 2'b11
  } cmd_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  typedef struct packed {
    cmd_op_t              op;
    logic [DEF_LEN_W-1:0] len;
  } cmd_t;

  localparam cmd_t CMD_NONE = '{op: OP_WAIT, len: {DEF_LEN_W{1'b0}}};

  function automatic logic op_is_legal(input cmd_op_t op);
    return op != OP_ILLEGAL;
  endfunction

endpackage

// File: rtl/seq_cmd_fifo.sv
// Small synchronous FIFO of step commands with occupancy count.
module seq_cmd_fifo
  import count_seq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  cmd_t             wdata,
  input  logic             pop,
  output cmd_t             rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0]    PTR_ONE = AW'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  cmd_t             mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] level_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (level_r == CNT_W'(DEPTH));
  assign empty     = (level_r == {CNT_W{1'b0}});
  assign level     = level_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally; level tracks push/pop balance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + CNT_ONE;
        2'b01:   level_r <= level_r - CNT_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/seq_strobe_chk.sv
// Protocol checker: the counter must never see both strobes at once.
module seq_strobe_chk (
  input logic clk,
  input logic reset,
  input logic up_down,
  input logic down_up
);

  strobe_exclusive: assert property (@(posedge clk) disable iff (!reset) !(up_down && down_up));

endmodule

// File: rtl/count_cmd_sequencer.sv
// Command sequencer: buffers step commands and expands each into per-cycle
// up/down strobes for the 4-bit counter.
module count_cmd_sequencer
  import count_seq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             hold,
  output logic             up_down,
  output logic             down_up,
  output logic [LEN_W-1:0] data,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_level,
  output logic             err
);

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1'b1);

  fsm_t             state_r;
  fsm_t             state_nxt_s;
  cmd_t             head_s;
  cmd_t             wr_cmd_s;
  cmd_t             act_r;
  logic [LEN_W-1:0] rem_r;
  logic [LEN_W-1:0] data_r;
  logic [LEN_W-1:0] data_nxt_s;
  logic             full_s;
  logic             empty_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic             illegal_s;
  logic             up_nxt_s;
  logic             down_nxt_s;
  logic             busy_nxt_s;
  logic             up_r;
  logic             down_r;
  logic             busy_r;
  logic             err_r;

  // Illegal ops complete the handshake but never reach the FIFO.
  assign cmd_ready = !full_s;
  assign accept_s  = cmd_valid && !full_s;
  assign wr_cmd_s  = '{op: cmd_op_t'(cmd_op), len: cmd_len};
  assign push_s    = accept_s && op_is_legal(wr_cmd_s.op);
  assign illegal_s = accept_s && !op_is_legal(wr_cmd_s.op);

  assign up_down = up_r;
  assign down_up = down_r;
  assign busy    = busy_r;
  assign data    = data_r;
  assign err     = err_r;

  seq_cmd_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .wdata (wr_cmd_s),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .level (fifo_level)
  );

  seq_strobe_chk u_chk (
    .clk     (clk),
    .reset   (reset),
    .up_down (up_r),
    .down_up (down_r)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and pop: the final step of a burst pops the next one for zero-bubble chaining.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          state_nxt_s = RUN;
          pop_s       = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (hold || (rem_r != LEN_ZERO)) begin
          state_nxt_s = RUN;
        end else if (!empty_s) begin
          state_nxt_s = RUN;
          pop_s       = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    up_nxt_s   = 1'b0;
    down_nxt_s = 1'b0;
    busy_nxt_s = 1'b0;
    data_nxt_s = LEN_ZERO;
    case (state_r)
      RUN: begin
        busy_nxt_s = 1'b1;
        data_nxt_s = act_r.len;
        if (hold) begin
          up_nxt_s   = 1'b0;
          down_nxt_s = 1'b0;
        end else begin
          up_nxt_s   = (act_r.op == OP_UP);
          down_nxt_s = (act_r.op == OP_DOWN);
        end
      end
      default: begin
        up_nxt_s   = 1'b0;
        down_nxt_s = 1'b0;
      end
    endcase
  end

  // Active command, remaining count, output registers and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_r  <= CMD_NONE;
      rem_r  <= LEN_ZERO;
      up_r   <= 1'b0;
      down_r <= 1'b0;
      busy_r <= 1'b0;
      data_r <= LEN_ZERO;
      err_r  <= 1'b0;
    end else begin
      if (pop_s) begin
        act_r <= head_s;
        rem_r <= head_s.len;
      end else if ((state_r == RUN) && !hold && (rem_r != LEN_ZERO)) begin
        rem_r <= rem_r - LEN_ONE;
      end
      up_r   <= up_nxt_s;
      down_r <= down_nxt_s;
      busy_r <= busy_nxt_s;
      data_r <= data_nxt_s;
      err_r  <= err_r || illegal_s;
    end
  end

endmodule
